// File: rtl/aca_var_latency_adder.sv
// aca_var_latency_adder: almost-correct adder with a ripple-group correction path behind valid/ready.
// Define ACA_ERR_COUNT_EN to add the saturating err_count output.
module aca_var_latency_adder #(
    parameter int WIDTH  = 16,
    parameter int WINDOW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             err_flag
`ifdef ACA_ERR_COUNT_EN
    ,
    output logic [15:0]      err_count
`endif
);
    localparam int K    = WINDOW - 1;
    localparam int NGRP = WIDTH / WINDOW;
    localparam int CW   = NGRP > 1 ? $clog2(NGRP) : 1;

    typedef enum logic [1:0] {IDLE, SPEC, CORR, HOLD} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic              cin_q, cin_d, cout_q, cout_d, err_q, err_d, cy_q, cy_d;
    logic [CW-1:0]     grp_q, grp_d;
    logic [WIDTH-1:0]  p, g;
    logic [WIDTH:0]    cs;
    logic              err;
    logic [WINDOW:0]   gsum;

    // Each carry only sees the K bits below it; cin joins when the window reaches bit 0.
    function automatic logic [WIDTH:0] spec_carry(logic [WIDTH-1:0] pp, gg, logic c0);
        logic [WIDTH:0] r;
        logic           c;
        r    = '0;
        r[0] = c0;
        for (int i = 1; i <= WIDTH; i++) begin
            c = (i <= K) ? c0 : 1'b0;
            for (int j = 0; j < i; j++)
                if (j >= i - K) c = gg[j] | (pp[j] & c);
            r[i] = c;
        end
        return r;
    endfunction

    // A full-window propagate run not anchored at bit 0 may hide a longer carry chain.
    function automatic logic spec_err(logic [WIDTH-1:0] pp);
        logic e;
        e = 1'b0;
        for (int i = K + 1; i <= WIDTH; i++) e = e | (&pp[i-1 -: K]);
        return e;
    endfunction

    always_comb begin
        p    = a_q ^ b_q;
        g    = a_q & b_q;
        cs   = spec_carry(p, g, cin_q);
        err  = spec_err(p);
        gsum = {1'b0, a_q[int'(grp_q)*WINDOW +: WINDOW]}
             + {1'b0, b_q[int'(grp_q)*WINDOW +: WINDOW]}
             + {{WINDOW{1'b0}}, cy_q};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        err_d   = err_q;
        cy_d    = cy_q;
        grp_d   = grp_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = a;
                b_d     = b;
                cin_d   = cin;
                state_d = SPEC;
            end
            SPEC: if (!err) begin
                sum_d   = p ^ cs[WIDTH-1:0];
                cout_d  = cs[WIDTH];
                err_d   = 1'b0;
                state_d = HOLD;
            end else begin
                grp_d   = '0;
                cy_d    = cin_q;
                state_d = CORR;
            end
            CORR: begin
                sum_d[int'(grp_q)*WINDOW +: WINDOW] = gsum[WINDOW-1:0];
                cy_d  = gsum[WINDOW];
                grp_d = grp_q + CW'(1);
                if (grp_q == CW'(NGRP - 1)) begin
                    cout_d  = gsum[WINDOW];
                    err_d   = 1'b1;
                    state_d = HOLD;
                end
            end
            default: if (out_ready) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            cy_q    <= 1'b0;
            grp_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
            cy_q    <= cy_d;
            grp_q   <= grp_d;
        end
    end

`ifdef ACA_ERR_COUNT_EN
    logic [15:0] cnt_q, cnt_d;
    assign cnt_d     = (state_q == SPEC && err && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    assign err_count = cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == HOLD;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign err_flag  = err_q;
endmodule
